char_ctrl: RTL and testbench
============================

CHAR_CTRL -- requirements
Module: char_ctrl

Interface
REQ-001 Parameter SCREEN_W, default 800, visible horizontal pixels.
REQ-002 Parameter GROUND_Y, default 580, y coordinate of the ground line (screen height minus 20).
REQ-003 Parameter STEP, default 4, horizontal pixels moved per frame.
REQ-004 Parameter JUMP_V0, default 16, initial upward velocity in pixels per frame.
REQ-005 Parameter GRAVITY, default 1, velocity change per frame.
REQ-006 Parameter VMAX, default 16, fall velocity saturation.
REQ-007 Parameter RST_HGT, default 32, half-height used for the reset position.
REQ-008 clk  in  1  system clock; all logic is on the rising edge.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 vblnk  in  1  vertical blank from the VGA timing chain.
REQ-011 left, right, jump  in  1 each  synchronous button levels, active-high.
REQ-012 char_hgt, char_lng  in  12 each  character half-height and half-width from the drawing stage.
REQ-013 pos_x, pos_y  out  12 each  character centre coordinates, fed to the drawing stage.
REQ-014 on_ground  out  1  high while the state is GROUND.

Function
REQ-015 Frame tick SHALL be asserted on a cycle when vblnk=1 and the registered previous vblnk=0; this gives one tick per frame.
REQ-016 All position, velocity and state updates SHALL occur only on tick cycles; outputs SHALL be registered, and new values SHALL appear on the clock edge that ends the tick cycle.
REQ-017 A jump rising edge (jump=1, previous jump=0) SHALL set jump_req; jump_req SHALL clear on every tick, whether or not it was consumed.
REQ-018 A jump edge coincident with a tick SHALL count for that tick.
REQ-019 Horizontal movement SHALL apply on each tick when exactly one of left or right is high; both or neither held SHALL leave pos_x unchanged.
REQ-020 Left movement: if pos_x - STEP < char_lng, pos_x SHALL become char_lng; otherwise pos_x SHALL become pos_x - STEP.
REQ-021 Right movement: if pos_x + STEP > SCREEN_W-1-char_lng, pos_x SHALL become SCREEN_W-1-char_lng; otherwise pos_x SHALL become pos_x + STEP.
REQ-022 All comparisons SHALL be performed at 13 bits so that no wrap-around occurs.
REQ-023 The state machine SHALL have three states: GROUND, RISE and FALL.
REQ-024 Vertical velocity vel SHALL be unsigned 8 bit.
REQ-025 GROUND: pos_y SHALL be held at GROUND_Y-char_hgt on every tick, so a change in char_hgt tracks the ground line.
REQ-026 GROUND with jump_req on a tick: next state SHALL be RISE and vel SHALL be JUMP_V0; pos_y SHALL be unchanged on that tick.
REQ-027 RISE, normal case: pos_y SHALL become pos_y-vel and vel SHALL become vel-GRAVITY.
REQ-028 RISE: when the new vel is 0, next state SHALL be FALL.
REQ-029 RISE top clamp: if pos_y-vel < char_hgt, pos_y SHALL become char_hgt, vel SHALL become 0 and next state SHALL be FALL.
REQ-030 FALL, normal case: vel SHALL become min(vel+GRAVITY, VMAX), then pos_y SHALL become pos_y+vel using the new vel.
REQ-031 FALL landing: if the result is >= GROUND_Y-char_hgt, pos_y SHALL become GROUND_Y-char_hgt, vel SHALL become 0 and next state SHALL be GROUND.
REQ-032 A jump_req in RISE or FALL SHALL be discarded; jumps are not buffered.
REQ-033 Horizontal and vertical updates SHALL be independent and SHALL be applied on the same tick.

Reset
REQ-034 While rst=0: pos_x=SCREEN_W/2 (400), pos_y=GROUND_Y-RST_HGT (548), vel=0, state=GROUND, on_ground=1, jump_req=0, and previous-sample registers for vblnk and jump=0.
REQ-035 Reset asserted mid-jump SHALL immediately force the REQ-034 values; the first tick after release SHALL behave as from GROUND.

Verification
REQ-036 Reset, then 10 ticks with no buttons and char_hgt=32, char_lng=25 -> pos_x=400, pos_y=548 and on_ground=1 throughout.
REQ-037 right held for 94 ticks -> pos_x=774 after tick 94 and remains 774 on tick 95; then left held -> pos_x decrements by 4 per tick and clamps at 25.
REQ-038 jump pulse then ticks -> RISE; pos_y 548, 532, 517, ... apex 412 after 16 ticks; FALL lands at 548 after 32 ticks in total; on_ground=0 during the flight.
REQ-039 jump pulse during FALL -> ignored; no new jump is taken on landing; a jump pressed after landing is accepted.
REQ-040 jump edge on the same cycle as a tick -> RISE is entered on that tick; left and right both held -> pos_x unchanged.
REQ-041 rst=0 pulse at the apex -> outputs return to 400/548 asynchronously, with on_ground=1.

Source files
------------

// File: rtl/char_ctrl_if.sv
// Signal bundle between the VGA/input stage and the character controller.
// master drives timing, buttons and sprite size; slave returns the position.
interface char_ctrl_if;
  logic        vblnk;
  logic        left;
  logic        right;
  logic        jump;
  logic [11:0] char_hgt;
  logic [11:0] char_lng;
  logic [11:0] pos_x;
  logic [11:0] pos_y;
  logic        on_ground;

  modport master (
    output vblnk, left, right, jump, char_hgt, char_lng,
    input  pos_x, pos_y, on_ground
  );

  modport slave (
    input  vblnk, left, right, jump, char_hgt, char_lng,
    output pos_x, pos_y, on_ground
  );
endinterface

// File: rtl/char_ctrl.sv
// Character movement controller: once per frame (rising edge of vblnk) moves
// the character horizontally with the buttons and runs a ground/rise/fall
// jump model with gravity, top clamp and landing on the ground line.
module char_ctrl #(
  parameter int unsigned SCREEN_W = 800,
  parameter int unsigned GROUND_Y = 580,
  parameter int unsigned STEP     = 4,
  parameter int unsigned JUMP_V0  = 16,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned VMAX     = 16,
  parameter int unsigned RST_HGT  = 32
) (
  input logic         clk,
  input logic         rst,
  char_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StGround, StRise, StFall} state_e;

  // Geometry is evaluated at 14 bits so sums of two 12-bit terms never wrap.
  localparam logic [13:0] ScreenMax = 14'(SCREEN_W - 1);
  localparam logic [13:0] GroundY   = 14'(GROUND_Y);
  localparam logic [13:0] StepW     = 14'(STEP);
  localparam logic [11:0] ResetX    = 12'(SCREEN_W / 2);
  localparam logic [11:0] ResetY    = 12'(GROUND_Y - RST_HGT);
  localparam logic [7:0]  JumpV0    = 8'(JUMP_V0);
  localparam logic [7:0]  Gravity   = 8'(GRAVITY);
  localparam logic [7:0]  Vmax      = 8'(VMAX);

  state_e      state_q, state_d;
  logic [11:0] pos_x_q, pos_x_d;
  logic [11:0] pos_y_q, pos_y_d;
  logic [7:0]  vel_q, vel_d;
  logic        vblnk_q, jump_q;
  logic        jump_req_q, jump_req_d;

  logic        tick, jump_edge, jump_take;
  logic [13:0] x_w, y_w, lng_w, hgt_w, ground_pos_w, fall_y_w;
  logic [8:0]  vel_sum;
  logic [7:0]  vel_fall;

  assign tick      = bus.vblnk & ~vblnk_q;
  assign jump_edge = bus.jump & ~jump_q;
  // An edge landing on the tick cycle itself still counts for that tick.
  assign jump_take = jump_req_q | jump_edge;

  assign x_w          = {2'b00, pos_x_q};
  assign y_w          = {2'b00, pos_y_q};
  assign lng_w        = {2'b00, bus.char_lng};
  assign hgt_w        = {2'b00, bus.char_hgt};
  assign ground_pos_w = GroundY - hgt_w;

  assign vel_sum  = {1'b0, vel_q} + {1'b0, Gravity};
  assign vel_fall = (vel_sum > {1'b0, Vmax}) ? Vmax : vel_sum[7:0];
  assign fall_y_w = y_w + {6'b0, vel_fall};

  // Jump request latch: set by a button edge, dropped on every tick.
  always_comb begin
    jump_req_d = jump_req_q | jump_edge;
    if (tick) begin
      jump_req_d = 1'b0;
    end
  end

  // Horizontal motion with clamping to the visible area.
  always_comb begin
    pos_x_d = pos_x_q;
    if (tick && (bus.left ^ bus.right)) begin
      if (bus.left) begin
        pos_x_d = (x_w < lng_w + StepW) ? bus.char_lng : pos_x_q - 12'(STEP);
      end else begin
        pos_x_d = (x_w + StepW + lng_w > ScreenMax) ? 12'(ScreenMax - lng_w)
                                                    : pos_x_q + 12'(STEP);
      end
    end
  end

  // Vertical FSM: next state, position and velocity.
  always_comb begin
    state_d = state_q;
    pos_y_d = pos_y_q;
    vel_d   = vel_q;
    if (tick) begin
      unique case (state_q)
        StGround: begin
          if (jump_take) begin
            state_d = StRise;
            vel_d   = JumpV0;
          end else begin
            pos_y_d = ground_pos_w[11:0];
          end
        end
        StRise: begin
          if (y_w < hgt_w + {6'b0, vel_q}) begin
            pos_y_d = bus.char_hgt;
            vel_d   = 8'd0;
            state_d = StFall;
          end else begin
            pos_y_d = pos_y_q - 12'(vel_q);
            if (vel_q <= Gravity) begin
              vel_d   = 8'd0;
              state_d = StFall;
            end else begin
              vel_d = vel_q - Gravity;
            end
          end
        end
        StFall: begin
          if (fall_y_w >= ground_pos_w) begin
            pos_y_d = ground_pos_w[11:0];
            vel_d   = 8'd0;
            state_d = StGround;
          end else begin
            pos_y_d = fall_y_w[11:0];
            vel_d   = vel_fall;
          end
        end
        default: state_d = StGround;
      endcase
    end
  end

  // State and output registers; reset parks the character on the ground.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StGround;
      pos_x_q    <= ResetX;
      pos_y_q    <= ResetY;
      vel_q      <= 8'd0;
      vblnk_q    <= 1'b0;
      jump_q     <= 1'b0;
      jump_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      vel_q      <= vel_d;
      vblnk_q    <= bus.vblnk;
      jump_q     <= bus.jump;
      jump_req_q <= jump_req_d;
    end
  end

  assign bus.pos_x     = pos_x_q;
  assign bus.pos_y     = pos_y_q;
  assign bus.on_ground = (state_q == StGround);

endmodule

// File: tb/tb_char_ctrl.sv
// Bench for char_ctrl: directed scenarios plus randomized frames, compared
// every cycle against a per-frame behavioural model of the character.
module tb_char_ctrl;
  localparam int W   = 800;
  localparam int GY  = 580;
  localparam int STP = 4;
  localparam int V0  = 16;
  localparam int G   = 1;
  localparam int VM  = 16;
  localparam int RH  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  char_ctrl_if bus();

  char_ctrl #(
    .SCREEN_W(W), .GROUND_Y(GY), .STEP(STP), .JUMP_V0(V0),
    .GRAVITY(G), .VMAX(VM), .RST_HGT(RH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Model: position, velocity, airborne phase (0 ground, 1 rising, 2 falling).
  int m_x, m_y, m_vel, m_mode;
  bit m_req, m_pv, m_pj;
  int n_err = 0;
  int n_chk = 0;

  function automatic void model_reset();
    m_x = W / 2; m_y = GY - RH; m_vel = 0; m_mode = 0;
    m_req = 0; m_pv = 0; m_pj = 0;
  endfunction

  function automatic void model_frame(bit jmp);
    int lng, hgt, floor_y;
    lng = int'(bus.char_lng);
    hgt = int'(bus.char_hgt);
    floor_y = GY - hgt;
    if (bus.left && !bus.right)
      m_x = (m_x - STP < lng) ? lng : m_x - STP;
    else if (bus.right && !bus.left)
      m_x = (m_x + STP > W - 1 - lng) ? W - 1 - lng : m_x + STP;
    case (m_mode)
      0: if (jmp) begin m_mode = 1; m_vel = V0; end else m_y = floor_y;
      1: begin
        if (m_y - m_vel < hgt) begin m_y = hgt; m_vel = 0; m_mode = 2; end
        else begin
          m_y = m_y - m_vel;
          m_vel = (m_vel > G) ? m_vel - G : 0;
          if (m_vel == 0) m_mode = 2;
        end
      end
      default: begin
        m_vel = (m_vel + G > VM) ? VM : m_vel + G;
        if (m_y + m_vel >= floor_y) begin m_y = floor_y; m_vel = 0; m_mode = 0; end
        else m_y = m_y + m_vel;
      end
    endcase
  endfunction

  function automatic void model_cycle();
    bit tick, edge_j;
    if (!rst) begin
      model_reset();
      return;
    end
    tick   = bus.vblnk && !m_pv;
    edge_j = bus.jump && !m_pj;
    if (tick) begin
      model_frame(m_req || edge_j);
      m_req = 0;
    end else if (edge_j) begin
      m_req = 1;
    end
    m_pv = bus.vblnk;
    m_pj = bus.jump;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    chk("pos_x", 32'(bus.pos_x), 32'(m_x));
    chk("pos_y", 32'(bus.pos_y), 32'(m_y));
    chk("on_ground", 32'(bus.on_ground), 32'(m_mode == 0));
  endtask

  task automatic frame(int gap);
    bus.vblnk = 1'b1;
    step();
    bus.vblnk = 1'b0;
    repeat (gap) step();
  endtask

  task automatic pulse_jump();
    bus.jump = 1'b1;
    step();
    bus.jump = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b0;
    bus.vblnk = 0; bus.left = 0; bus.right = 0; bus.jump = 0;
    bus.char_hgt = 12'd32; bus.char_lng = 12'd25;
    model_reset();
    step(); step();
    chk("rst_x", 32'(bus.pos_x), 32'd400);
    chk("rst_y", 32'(bus.pos_y), 32'd548);
    chk("rst_og", 32'(bus.on_ground), 32'd1);
    rst = 1'b1;
    step();

    // Idle frames: character stays parked.
    for (int i = 0; i < 10; i++) begin
      frame(3);
      chk("idle_x", 32'(bus.pos_x), 32'd400);
      chk("idle_y", 32'(bus.pos_y), 32'd548);
    end

    // Right to the clamp, then left to the clamp.
    bus.right = 1'b1;
    for (int i = 1; i <= 95; i++) begin
      frame(2);
      if (i >= 94) chk("right_clamp", 32'(bus.pos_x), 32'd774);
    end
    bus.right = 1'b0;
    bus.left  = 1'b1;
    frame(2);
    chk("left_step", 32'(bus.pos_x), 32'd770);
    for (int i = 0; i < 190; i++) frame(2);
    chk("left_clamp", 32'(bus.pos_x), 32'd25);
    bus.left = 1'b0;

    // Full jump arc; a jump during the fall is ignored.
    pulse_jump();
    frame(3);
    chk("jump_y", 32'(bus.pos_y), 32'd548);
    chk("jump_og", 32'(bus.on_ground), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      frame(3);
      if (i == 1)  chk("rise1", 32'(bus.pos_y), 32'd532);
      if (i == 2)  chk("rise2", 32'(bus.pos_y), 32'd517);
      if (i == 16) chk("apex", 32'(bus.pos_y), 32'd412);
    end
    for (int i = 1; i <= 16; i++) begin
      frame(3);
      if (i == 8) pulse_jump();
      if (i == 15) chk("fall_og", 32'(bus.on_ground), 32'd0);
    end
    chk("land_y", 32'(bus.pos_y), 32'd548);
    chk("land_og", 32'(bus.on_ground), 32'd1);
    frame(3);
    chk("no_rejump", 32'(bus.on_ground), 32'd1);
    pulse_jump();
    frame(3);
    chk("rejump", 32'(bus.on_ground), 32'd0);
    for (int i = 0; i < 32; i++) frame(3);
    chk("reland", 32'(bus.on_ground), 32'd1);

    // Jump edge on the tick cycle, both directions held, reset at apex.
    bus.left = 1'b1; bus.right = 1'b1;
    bus.jump = 1'b1; bus.vblnk = 1'b1;
    step();
    chk("coinc_og", 32'(bus.on_ground), 32'd0);
    bus.jump = 1'b0; bus.vblnk = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 16; i++) frame(3);
    chk("both_x", 32'(bus.pos_x), 32'd25);
    chk("apex2", 32'(bus.pos_y), 32'd412);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_x", 32'(bus.pos_x), 32'd400);
    chk("async_y", 32'(bus.pos_y), 32'd548);
    chk("async_og", 32'(bus.on_ground), 32'd1);
    bus.left = 1'b0; bus.right = 1'b0;
    step();
    rst = 1'b1;
    step();
    frame(3);
    chk("post_rst_y", 32'(bus.pos_y), 32'd548);
    chk("post_rst_og", 32'(bus.on_ground), 32'd1);

    // Randomized frames against the model.
    for (int i = 0; i < 300; i++) begin
      bus.left  = 1'($urandom_range(0, 1));
      bus.right = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) bus.char_lng = 12'($urandom_range(10, 60));
      if ($urandom_range(0, 15) == 0) bus.char_hgt = 12'($urandom_range(16, 40));
      if ($urandom_range(0, 5) == 0) pulse_jump();
      bus.jump = 1'($urandom_range(0, 7) == 0);
      bus.vblnk = 1'b1;
      step();
      bus.jump = 1'b0;
      bus.vblnk = 1'b0;
      repeat ($urandom_range(1, 4)) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
